uart_word_tx: RTL

- UART transmitter, 8N1, serialising 32-bit words as four bytes, least-significant byte first.
- Outbound counterpart of the UART loader path in cpu_uart_top: it streams words such as register-file or ALU results from the core to the host.
- It also acts as the host-side program sender in benches, feeding the loader's receiver the same byte order the loader expects.
- Fixed line format: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1), no parity.

---
 rtl/uart_word_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_word_tx.sv
// 8N1 UART transmitter that serialises one accepted word as BYTES_PER_WORD
// back-to-back frames, least-significant byte first.
module uart_word_tx #(
    parameter int CLKS_PER_BIT   = 16,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [8*BYTES_PER_WORD-1:0]   word_in,
    input  logic                          word_valid,
    output logic                          word_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          byte_sent
);

    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              r_state;
    logic [BAUD_W-1:0]   r_baudCnt;
    logic [2:0]          r_bitIdx;
    logic [BYTE_W-1:0]   r_byteIdx;
    logic [WORD_W-1:0]   r_shiftBuf;
    logic                r_tx;
    logic                r_byteSent;

    state_t              w_stateNext;
    logic [BAUD_W-1:0]   w_baudNext;
    logic [2:0]          w_bitNext;
    logic [BYTE_W-1:0]   w_byteNext;
    logic [WORD_W-1:0]   w_shiftNext;
    logic                w_bitDone;
    logic                w_accept;
    logic [7:0]          w_curByte;
    logic                w_txNext;
    logic                w_byteSentNext;

    assign word_ready = (r_state == S_IDLE) && !rst;
    assign w_accept   = word_valid && word_ready;
    assign w_bitDone  = (r_baudCnt == LAST_BAUD);

    always_comb begin
        w_stateNext = r_state;
        w_baudNext  = r_baudCnt;
        w_bitNext   = r_bitIdx;
        w_byteNext  = r_byteIdx;
        w_shiftNext = r_shiftBuf;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stateNext = S_START;
                    w_shiftNext = word_in;
                    w_byteNext  = '0;
                    w_baudNext  = '0;
                end
            end
            S_START: begin
                if (w_bitDone) begin
                    w_stateNext = S_DATA;
                    w_baudNext  = '0;
                    w_bitNext   = '0;
                end else begin
                    w_baudNext  = r_baudCnt + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_bitDone) begin
                    w_baudNext = '0;
                    if (r_bitIdx == 3'd7) begin
                        w_stateNext = S_STOP;
                    end else begin
                        w_bitNext = r_bitIdx + 3'd1;
                    end
                end else begin
                    w_baudNext = r_baudCnt + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (w_bitDone) begin
                    w_baudNext = '0;
                    if (r_byteIdx < LAST_BYTE) begin
                        w_stateNext = S_START;
                        w_shiftNext = r_shiftBuf >> 8;
                        w_byteNext  = r_byteIdx + BYTE_W'(1);
                    end else begin
                        w_stateNext = S_IDLE;
                    end
                end else begin
                    w_baudNext = r_baudCnt + BAUD_W'(1);
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // tx and byte_sent are registered from the next-state values so they line up with r_state.
    always_comb begin
        w_curByte = w_shiftNext[7:0];
        w_txNext  = 1'b1;
        case (w_stateNext)
            S_START: w_txNext = 1'b0;
            S_DATA:  w_txNext = w_curByte[w_bitNext];
            default: w_txNext = 1'b1;
        endcase
        w_byteSentNext = (w_stateNext == S_STOP) && (w_baudNext == LAST_BAUD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baudCnt  <= '0;
            r_bitIdx   <= '0;
            r_byteIdx  <= '0;
            r_shiftBuf <= '0;
            r_tx       <= 1'b1;
            r_byteSent <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_baudCnt  <= w_baudNext;
            r_bitIdx   <= w_bitNext;
            r_byteIdx  <= w_byteNext;
            r_shiftBuf <= w_shiftNext;
            r_tx       <= w_txNext;
            r_byteSent <= w_byteSentNext;
        end
    end

    assign tx        = r_tx;
    assign busy      = (r_state != S_IDLE);
    assign byte_sent = r_byteSent;

endmodule
